// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - op encodings for MULT, MULTU, DIV, DIVU
//   - control state enum (IDLE, CALC, FIXUP)
//   - default operand width
//   - small decode helpers for the op field
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CALC  = 2'b01,
      FIXUP = 2'b10
   } mdu_state_e;

   // Divide ops have the upper op bit set.
   function automatic logic op_is_div(input logic [1:0] op_code);
      return op_code[1];
   endfunction

   // Signed ops have the lower op bit clear.
   function automatic logic op_is_signed(input logic [1:0] op_code);
      return ~op_code[0];
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
//   rem       : partial remainder before this step
//   dvd_bit   : next dividend bit shifted into the remainder
//   divisor   : divisor magnitude
//   rem_out   : partial remainder after this step
//   q_bit     : quotient bit produced by this step
module mdu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0]   shifted_s;
   logic [WIDTH-1:0] diff_s;
   logic             fits_s;

   // Trial subtraction. When the divisor fits, the true difference is below
   // the divisor, so a WIDTH-bit modular subtract is exact.
   always_comb begin
      shifted_s = {rem, dvd_bit};
      fits_s    = (shifted_s >= {1'b0, divisor});
      diff_s    = shifted_s[WIDTH-1:0] - divisor;
      if (fits_s) begin
         rem_out = diff_s;
         q_bit   = 1'b1;
      end else begin
         rem_out = shifted_s[WIDTH-1:0];
         q_bit   = 1'b0;
      end
   end

endmodule

// File: rtl/mdu_hilo_src.sv
// mdu_hilo_src: iterative radix-2 multiply/divide unit producing HI/LO.
// Build option: MDU_EARLY_OUT_EN lets multiplies leave CALC once the
// remaining multiplier bits are zero (divide timing is unchanged).
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   start    : request pulse, sampled only in IDLE
//   op       : 00=MULT 01=MULTU 10=DIV 11=DIVU
//   src_a    : multiplicand / dividend
//   src_b    : multiplier / divisor
//   cancel   : pipeline flush, aborts any operation
//   busy     : operation in progress
//   done     : one-cycle result-valid pulse
//   hilo_we  : HI/LO write enable, coincident with done
//   hi_out   : product high half or remainder
//   lo_out   : product low half or quotient
module mdu_hilo_src import mdu_pkg::*; #(
   parameter int WIDTH = MDU_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             hilo_we,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   mdu_state_e         state_r, state_nxt;
   logic [CNT_W-1:0]   cnt_r, cnt_nxt;
   // Shared accumulator: mul {partial product, multiplier}, div {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] acc_r, acc_nxt;
   // Multiplicand magnitude or divisor magnitude
   logic [WIDTH-1:0]   opnd_r, opnd_nxt;
   logic [WIDTH-1:0]   a_raw_r, a_raw_nxt;
   logic               is_div_r, is_div_nxt;
   logic               neg_lo_r, neg_lo_nxt;
   logic               neg_hi_r, neg_hi_nxt;
   logic               divz_r, divz_nxt;
   logic [WIDTH-1:0]   hi_r, hi_nxt;
   logic [WIDTH-1:0]   lo_r, lo_nxt;
   logic               busy_r, busy_nxt;
   logic               done_r, done_nxt;
   logic               we_r, we_nxt;

   logic               a_neg_s, b_neg_s;
   logic [WIDTH-1:0]   mag_a_s, mag_b_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [2*WIDTH-1:0] mul_acc_s;
   logic [2*WIDTH-1:0] div_acc_s;
   logic [2*WIDTH-1:0] step_acc_s;
   logic [WIDTH-1:0]   div_rem_s;
   logic               div_q_s;
   logic               last_s;
   logic [2*WIDTH-1:0] aligned_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s, rem_s;

   // Operand magnitudes and signs for the request presented at the ports.
   always_comb begin
      a_neg_s = op_is_signed(op) & src_a[WIDTH-1];
      b_neg_s = op_is_signed(op) & src_b[WIDTH-1];
      if (a_neg_s) begin
         mag_a_s = {WIDTH{1'b0}} - src_a;
      end else begin
         mag_a_s = src_a;
      end
      if (b_neg_s) begin
         mag_b_s = {WIDTH{1'b0}} - src_b;
      end else begin
         mag_b_s = src_b;
      end
   end

   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem     (acc_r[2*WIDTH-1:WIDTH]),
      .dvd_bit (acc_r[WIDTH-1]),
      .divisor (opnd_r),
      .rem_out (div_rem_s),
      .q_bit   (div_q_s)
   );

   // One iteration of shift-add multiply and restoring divide.
   always_comb begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                + ({1'b0, opnd_r} & {(WIDTH+1){acc_r[0]}});
      mul_acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      div_acc_s = {div_rem_s, acc_r[WIDTH-2:0], div_q_s};
      if (is_div_r) begin
         step_acc_s = div_acc_s;
      end else begin
         step_acc_s = mul_acc_s;
      end
   end

`ifdef MDU_EARLY_OUT_EN
   logic [CNT_W-1:0] mask_sh_s;
   logic [WIDTH-1:0] rem_mask_s;
   logic [CNT_W-1:0] align_sh_s;

   // Multiply may stop once no multiplier bits remain; FIXUP then applies the
   // outstanding right shifts in one go.
   always_comb begin
      mask_sh_s  = cnt_r + CNT_W'(1);
      rem_mask_s = {WIDTH{1'b1}} >> mask_sh_s;
      align_sh_s = CNT_W'(WIDTH - 1) - cnt_r;
      aligned_s  = acc_r >> align_sh_s;
      if (cnt_r == CNT_W'(WIDTH - 1)) begin
         last_s = 1'b1;
      end else if (!is_div_r && ((mul_acc_s[WIDTH-1:0] & rem_mask_s) == {WIDTH{1'b0}})) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end
   end
`else
   // Fixed iteration count for every op.
   always_comb begin
      aligned_s = acc_r;
      if (cnt_r == CNT_W'(WIDTH - 1)) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end
   end
`endif

   // Sign fixup of magnitude results.
   always_comb begin
      if (neg_lo_r) begin
         prod_s = {(2*WIDTH){1'b0}} - aligned_s;
         quo_s  = {WIDTH{1'b0}} - acc_r[WIDTH-1:0];
      end else begin
         prod_s = aligned_s;
         quo_s  = acc_r[WIDTH-1:0];
      end
      if (neg_hi_r) begin
         rem_s = {WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH];
      end else begin
         rem_s = acc_r[2*WIDTH-1:WIDTH];
      end
   end

   // Next-state and next-value logic for control and datapath registers.
   always_comb begin
      state_nxt  = state_r;
      cnt_nxt    = cnt_r;
      acc_nxt    = acc_r;
      opnd_nxt   = opnd_r;
      a_raw_nxt  = a_raw_r;
      is_div_nxt = is_div_r;
      neg_lo_nxt = neg_lo_r;
      neg_hi_nxt = neg_hi_r;
      divz_nxt   = divz_r;
      hi_nxt     = hi_r;
      lo_nxt     = lo_r;
      done_nxt   = 1'b0;
      we_nxt     = 1'b0;
      case (state_r)
         IDLE: begin
            if (start && !cancel) begin
               state_nxt  = CALC;
               cnt_nxt    = {CNT_W{1'b0}};
               is_div_nxt = op_is_div(op);
               a_raw_nxt  = src_a;
               if (op_is_div(op)) begin
                  acc_nxt    = {{WIDTH{1'b0}}, mag_a_s};
                  opnd_nxt   = mag_b_s;
                  neg_lo_nxt = a_neg_s ^ b_neg_s;
                  neg_hi_nxt = a_neg_s;
                  divz_nxt   = (src_b == {WIDTH{1'b0}});
               end else begin
                  acc_nxt    = {{WIDTH{1'b0}}, mag_b_s};
                  opnd_nxt   = mag_a_s;
                  neg_lo_nxt = a_neg_s ^ b_neg_s;
                  neg_hi_nxt = a_neg_s ^ b_neg_s;
                  divz_nxt   = 1'b0;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         CALC: begin
            if (cancel) begin
               state_nxt = IDLE;
            end else begin
               acc_nxt = step_acc_s;
               if (last_s) begin
                  state_nxt = FIXUP;
               end else begin
                  cnt_nxt = cnt_r + CNT_W'(1);
               end
            end
         end
         FIXUP: begin
            state_nxt = IDLE;
            if (cancel) begin
               done_nxt = 1'b0;
            end else begin
               done_nxt = 1'b1;
               we_nxt   = 1'b1;
               if (!is_div_r) begin
                  hi_nxt = prod_s[2*WIDTH-1:WIDTH];
                  lo_nxt = prod_s[WIDTH-1:0];
               end else if (divz_r) begin
                  // Divide by zero reports the latched dividend unmodified.
                  hi_nxt = a_raw_r;
                  lo_nxt = {WIDTH{1'b1}};
               end else begin
                  hi_nxt = rem_s;
                  lo_nxt = quo_s;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         acc_r    <= {(2*WIDTH){1'b0}};
         opnd_r   <= {WIDTH{1'b0}};
         a_raw_r  <= {WIDTH{1'b0}};
         is_div_r <= 1'b0;
         neg_lo_r <= 1'b0;
         neg_hi_r <= 1'b0;
         divz_r   <= 1'b0;
         hi_r     <= {WIDTH{1'b0}};
         lo_r     <= {WIDTH{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         we_r     <= 1'b0;
      end else begin
         state_r  <= state_nxt;
         cnt_r    <= cnt_nxt;
         acc_r    <= acc_nxt;
         opnd_r   <= opnd_nxt;
         a_raw_r  <= a_raw_nxt;
         is_div_r <= is_div_nxt;
         neg_lo_r <= neg_lo_nxt;
         neg_hi_r <= neg_hi_nxt;
         divz_r   <= divz_nxt;
         hi_r     <= hi_nxt;
         lo_r     <= lo_nxt;
         busy_r   <= busy_nxt;
         done_r   <= done_nxt;
         we_r     <= we_nxt;
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign hilo_we = we_r;
   assign hi_out  = hi_r;
   assign lo_out  = lo_r;

endmodule

// File: tb/tb_mdu_hilo_src.sv
// tb_mdu_hilo_src: directed bench for mdu_hilo_src (vector table plus
// hand-written cancel / busy-start / async-reset sequences).
module tb_mdu_hilo_src;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic          clk;
   logic          rst;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  src_a;
   logic [W-1:0]  src_b;
   logic          cancel;
   logic          busy;
   logic          done;
   logic          hilo_we;
   logic [W-1:0]  hi_out;
   logic [W-1:0]  lo_out;

   int total;
   int bad;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   vec_t vecs[12];

   mdu_hilo_src #(.WIDTH(W), .CNT_W(6)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .src_a   (src_a),
      .src_b   (src_b),
      .cancel  (cancel),
      .busy    (busy),
      .done    (done),
      .hilo_we (hilo_we),
      .hi_out  (hi_out),
      .lo_out  (lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one operation and wait (bounded) for done; checks handshake timing.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] hi_s, output logic [W-1:0] lo_s);
      @(posedge clk); #1;
      op = o; src_a = a; src_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      lat = 0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
      end
      hi_s = hi_out;
      lo_s = lo_out;
      check("done_seen", {31'd0, (lat != 0)}, 32'd1);
      check("we_with_done", {31'd0, hilo_we}, {31'd0, done});
      check("busy_low_at_done", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("we_one_cycle", {31'd0, hilo_we}, 32'd0);
   endtask

   initial begin
      int lat;
      int dones;
      logic [W-1:0] hi_s, lo_s;
      total = 0;
      bad   = 0;
      rst    = 1'b0;
      start  = 1'b0;
      cancel = 1'b0;
      op     = 2'b00;
      src_a  = 32'd0;
      src_b  = 32'd0;

      vecs[0]  = '{op: 2'b00, a: 32'hFFFF_FFFD, b: 32'h0000_0007, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB};
      vecs[1]  = '{op: 2'b01, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFE, lo: 32'h0000_0001};
      vecs[2]  = '{op: 2'b10, a: 32'hFFFF_FFF9, b: 32'h0000_0002, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD};
      vecs[3]  = '{op: 2'b11, a: 32'h0000_0064, b: 32'h0000_0000, hi: 32'h0000_0064, lo: 32'hFFFF_FFFF};
      vecs[4]  = '{op: 2'b10, a: 32'h8000_0000, b: 32'hFFFF_FFFF, hi: 32'h0000_0000, lo: 32'h8000_0000};
      vecs[5]  = '{op: 2'b00, a: 32'h0000_0005, b: 32'h0000_0006, hi: 32'h0000_0000, lo: 32'h0000_001E};
      vecs[6]  = '{op: 2'b11, a: 32'h0000_0064, b: 32'h0000_0007, hi: 32'h0000_0002, lo: 32'h0000_000E};
      vecs[7]  = '{op: 2'b10, a: 32'h0000_0007, b: 32'hFFFF_FFFE, hi: 32'h0000_0001, lo: 32'hFFFF_FFFD};
      vecs[8]  = '{op: 2'b00, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, hi: 32'h0000_0000, lo: 32'h0000_0001};
      vecs[9]  = '{op: 2'b10, a: 32'hFFFF_FFFB, b: 32'h0000_0000, hi: 32'hFFFF_FFFB, lo: 32'hFFFF_FFFF};
      vecs[10] = '{op: 2'b01, a: 32'h1234_5678, b: 32'h0000_0003, hi: 32'h0000_0000, lo: 32'h369D_0368};
      vecs[11] = '{op: 2'b00, a: 32'h8000_0000, b: 32'h8000_0000, hi: 32'h4000_0000, lo: 32'h0000_0000};

      // Reset state
      #2;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_we", {31'd0, hilo_we}, 32'd0);
      check("rst_hi", hi_out, 32'd0);
      check("rst_lo", lo_out, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Vector table
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, hi_s, lo_s);
         check($sformatf("vec%0d_hi", i), hi_s, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), lo_s, vecs[i].lo);
`ifdef MDU_EARLY_OUT_EN
         if (vecs[i].op[1]) begin
            check($sformatf("vec%0d_lat", i), lat, LAT);
         end else if (i == 10) begin
            check($sformatf("vec%0d_lat_early", i), {31'd0, (lat >= 1 && lat <= 4)}, 32'd1);
         end else begin
            check($sformatf("vec%0d_lat_max", i), {31'd0, (lat >= 1 && lat <= LAT)}, 32'd1);
         end
`else
         check($sformatf("vec%0d_lat", i), lat, LAT);
`endif
      end

      // Known prior result before the cancel sequence: DIVU 100/7
      run_op(2'b11, 32'd100, 32'd7, lat, hi_s, lo_s);
      check("pre_cancel_lo", lo_s, 32'd14);

      // Cancel mid-divide at cycle 10
      @(posedge clk); #1;
      op = 2'b10; src_a = 32'h0000_7FFF; src_b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      check("cancel_busy_low", {31'd0, busy}, 32'd0);
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done || hilo_we) dones++;
      end
      check("cancel_no_done", dones, 32'd0);
      check("cancel_hi_kept", hi_out, 32'd2);
      check("cancel_lo_kept", lo_out, 32'd14);

      // Start together with cancel in IDLE is dropped
      @(posedge clk); #1;
      op = 2'b00; src_a = 32'd9; src_b = 32'd9; start = 1'b1; cancel = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      check("start_cancel_idle", {31'd0, busy}, 32'd0);

      // Second start while busy is ignored
      @(posedge clk); #1;
      op = 2'b11; src_a = 32'd1000; src_b = 32'd10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      op = 2'b00; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dones = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("busy_start_single_done", dones, 32'd1);
      check("busy_start_lo", lo_out, 32'd100);
      check("busy_start_hi", hi_out, 32'd0);

      // Asynchronous reset mid-CALC
      @(posedge clk); #1;
      op = 2'b01; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_we", {31'd0, hilo_we}, 32'd0);
      check("arst_hi", hi_out, 32'd0);
      check("arst_lo", lo_out, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      run_op(2'b00, 32'd5, 32'd6, lat, hi_s, lo_s);
      check("post_rst_lo", lo_s, 32'd30);
      check("post_rst_hi", hi_s, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
